// File: rtl/burst_arb_pkg.sv
// Shared types and widths for the two-requester burst bus arbiter.
package burst_arb_pkg;

   localparam int ADDR_W = 21;
   localparam int DATA_W = 64;
   localparam int MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      WR_DATA = 2'd2,
      RD_DATA = 2'd3
   } arb_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      if (val == 16'hFFFF) begin
         res = val;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/burst_bus_if.sv
// Burst memory bus: one command phase followed by BURST_LEN data beats.
interface burst_bus_if;
   import burst_arb_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic              cmd;
   logic              cmd_en;
   logic              ready;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] data_mask;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;

   modport slave (
      input  addr, cmd, cmd_en, wr_data, data_mask,
      output ready, rd_data, rd_data_valid
   );

   modport master (
      output addr, cmd, cmd_en, wr_data, data_mask,
      input  ready, rd_data, rd_data_valid
   );

endinterface

// File: rtl/burst_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not served last wins a tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant
);

   logic prio_q;
   logic prio_d;

   // Grant selection and priority update after each accepted grant
   always_comb begin
      grant  = 1'b0;
      prio_d = prio_q;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = prio_q;
         default: grant = 1'b0;
      endcase
      if (advance) begin
         prio_d = ~grant;
      end else begin
         prio_d = prio_q;
      end
   end

   // Priority pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/burst_bus_arbiter.sv
// Arbitrates two burst requesters onto one memory port with read timeout.
// Optional statistics outputs are enabled by defining BURST_ARB_STATS_EN.
module burst_bus_arbiter
   import burst_arb_pkg::*;
#(
   parameter int BURST_LEN  = 4,
   parameter int RD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   burst_bus_if.slave  s0,
   burst_bus_if.slave  s1,
   burst_bus_if.master m,
   output logic        rd_timeout_err
`ifdef BURST_ARB_STATS_EN
   ,
   output logic [15:0] grants0,
   output logic [15:0] grants1,
   output logic [31:0] busy_cycles
`endif
);

   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
   localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(RD_TIMEOUT - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
   localparam logic [TMO_W-1:0]  TMO_ZERO  = TMO_W'(0);

   arb_state_e        state_q,  state_d;
   logic              owner_q,  owner_d;
   logic              cmd_en_q, cmd_en_d;
   logic              cmd_q,    cmd_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [BEAT_W-1:0] beat_q,   beat_d;
   logic [TMO_W-1:0]  tmo_q,    tmo_d;
   logic              err_q,    err_d;

   logic [1:0] req;
   logic       advance;
   logic       grant_idx;

   assign req = {s1.cmd_en, s0.cmd_en};

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (advance),
      .grant   (grant_idx)
   );

   // Next-state logic; address and command are captured at grant time
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cmd_en_d = 1'b0;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      tmo_d    = tmo_q;
      err_d    = 1'b0;
      advance  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               advance  = 1'b1;
               owner_d  = grant_idx;
               state_d  = CMD;
               cmd_en_d = 1'b1;
               addr_d   = grant_idx ? s1.addr : s0.addr;
               cmd_d    = grant_idx ? s1.cmd  : s0.cmd;
               beat_d   = BEAT_ZERO;
               tmo_d    = TMO_ZERO;
            end else begin
               state_d = IDLE;
            end
         end
         CMD: begin
            if (m.ready) begin
               if (cmd_q) begin
                  // beat 0 moves in this cycle; a single-beat burst is already done
                  if (BURST_LEN > 1) begin
                     state_d = WR_DATA;
                     beat_d  = BEAT_ONE;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = RD_DATA;
                  beat_d  = BEAT_ZERO;
                  tmo_d   = TMO_ZERO;
               end
            end else begin
               cmd_en_d = 1'b1;
            end
         end
         WR_DATA: begin
            if (beat_q == LAST_BEAT) begin
               state_d = IDLE;
            end else begin
               beat_d = beat_q + BEAT_ONE;
            end
         end
         RD_DATA: begin
            // a final beat landing on the last allowed cycle still completes
            if (m.rd_data_valid && (beat_q == LAST_BEAT)) begin
               state_d = IDLE;
            end else if (tmo_q == LAST_TMO) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
               if (m.rd_data_valid) begin
                  beat_d = beat_q + BEAT_ONE;
               end else begin
                  beat_d = beat_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and command registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         cmd_en_q <= 1'b0;
         cmd_q    <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         beat_q   <= BEAT_ZERO;
         tmo_q    <= TMO_ZERO;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cmd_en_q <= cmd_en_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
      end
   end

   // Bus routing; write data is blanked outside a write so aborted bursts stop cleanly
   always_comb begin
      m.cmd_en         = cmd_en_q;
      m.addr           = addr_q;
      m.cmd            = cmd_q;
      m.data_mask      = owner_q ? s1.data_mask : s0.data_mask;
      m.wr_data        = {DATA_W{1'b0}};
      s0.ready         = 1'b0;
      s1.ready         = 1'b0;
      s0.rd_data       = {DATA_W{1'b0}};
      s1.rd_data       = {DATA_W{1'b0}};
      s0.rd_data_valid = 1'b0;
      s1.rd_data_valid = 1'b0;
      if ((state_q == CMD) || (state_q == WR_DATA)) begin
         m.wr_data = owner_q ? s1.wr_data : s0.wr_data;
      end else begin
         m.wr_data = {DATA_W{1'b0}};
      end
      if (state_q == CMD) begin
         if (owner_q) begin
            s1.ready = m.ready;
         end else begin
            s0.ready = m.ready;
         end
      end else begin
         s0.ready = 1'b0;
         s1.ready = 1'b0;
      end
      if (state_q == RD_DATA) begin
         if (owner_q) begin
            s1.rd_data       = m.rd_data;
            s1.rd_data_valid = m.rd_data_valid;
         end else begin
            s0.rd_data       = m.rd_data;
            s0.rd_data_valid = m.rd_data_valid;
         end
      end else begin
         s0.rd_data_valid = 1'b0;
         s1.rd_data_valid = 1'b0;
      end
   end

   assign rd_timeout_err = err_q;

`ifdef BURST_ARB_STATS_EN
   logic [15:0] grants0_q, grants0_d;
   logic [15:0] grants1_q, grants1_d;
   logic [31:0] busy_q,    busy_d;

   // Grant tallies saturate; busy count wraps
   always_comb begin
      grants0_d = grants0_q;
      grants1_d = grants1_q;
      busy_d    = busy_q;
      if (advance) begin
         if (grant_idx) begin
            grants1_d = sat_inc16(grants1_q);
         end else begin
            grants0_d = sat_inc16(grants0_q);
         end
      end else begin
         grants0_d = grants0_q;
         grants1_d = grants1_q;
      end
      if (state_q != IDLE) begin
         busy_d = busy_q + 32'd1;
      end else begin
         busy_d = busy_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         grants0_q <= 16'd0;
         grants1_q <= 16'd0;
         busy_q    <= 32'd0;
      end else begin
         grants0_q <= grants0_d;
         grants1_q <= grants1_d;
         busy_q    <= busy_d;
      end
   end

   assign grants0     = grants0_q;
   assign grants1     = grants1_q;
   assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Self-checking bench for burst_bus_arbiter: directed table, corner sequences, random traffic.
module tb_burst_bus_arbiter;

   localparam int BL  = 4;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic reset;
   logic rd_timeout_err;
`ifdef BURST_ARB_STATS_EN
   logic [15:0] grants0;
   logic [15:0] grants1;
   logic [31:0] busy_cycles;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   logic pri;   // requester that wins a tie next

   burst_bus_if s0_if ();
   burst_bus_if s1_if ();
   burst_bus_if m_if ();

   always #5 clk = ~clk;

   burst_bus_arbiter #(.BURST_LEN(BL), .RD_TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .s0             (s0_if),
      .s1             (s1_if),
      .m              (m_if),
      .rd_timeout_err (rd_timeout_err)
`ifdef BURST_ARB_STATS_EN
      ,
      .grants0        (grants0),
      .grants1        (grants1),
      .busy_cycles    (busy_cycles)
`endif
   );

   typedef struct {
      logic [1:0]  reqm;
      logic        cmd;
      logic [20:0] a0;
      logic [20:0] a1;
      int          lat;
      int          nvalid;
      logic [63:0] base;
      logic        exp_own;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_wr(input logic own, input logic [63:0] v);
      s0_if.wr_data = own ? ~v : v;
      s1_if.wr_data = own ? v : ~v;
   endtask

   // One complete transaction; the expected owner comes from the caller
   task automatic run_txn(input logic [1:0] reqm, input logic cmd, input logic [20:0] a0,
                          input logic [20:0] a1, input int lat, input int nvalid,
                          input logic [63:0] base, input logic exp_own, input bit gaps,
                          input string tag);
      logic [20:0] exp_addr;
      logic [7:0]  exp_mask;
      logic        vld;
      bit          timed_out;
      int          got;
      exp_addr = exp_own ? a1 : a0;
      exp_mask = exp_own ? 8'hF0 : 8'h0F;
      s0_if.cmd_en = reqm[0];
      s1_if.cmd_en = reqm[1];
      s0_if.cmd = cmd;
      s1_if.cmd = cmd;
      s0_if.addr = a0;
      s1_if.addr = a1;
      drive_wr(exp_own, base);
      m_if.ready = 1'b0;
      m_if.rd_data_valid = 1'b0;
      #1;
      check({tag, " idle cmd_en"}, 64'(m_if.cmd_en), 64'd0);
      check({tag, " idle err"}, 64'(rd_timeout_err), 64'd0);
      pri = ~exp_own;
      for (int i = 0; i <= lat; i++) begin
         tick();
         m_if.ready = (i == lat);
         #1;
         check({tag, " cmd_en"}, 64'(m_if.cmd_en), 64'd1);
         check({tag, " addr"}, 64'(m_if.addr), 64'(exp_addr));
         check({tag, " cmd"}, 64'(m_if.cmd), 64'(cmd));
         check({tag, " own ready"}, 64'(exp_own ? s1_if.ready : s0_if.ready), 64'(m_if.ready));
         check({tag, " other ready"}, 64'(exp_own ? s0_if.ready : s1_if.ready), 64'd0);
         check({tag, " mask"}, 64'(m_if.data_mask), 64'(exp_mask));
         if (cmd) check({tag, " beat0"}, m_if.wr_data, base);
      end
      tick();
      s0_if.cmd_en = 1'b0;
      s1_if.cmd_en = 1'b0;
      m_if.ready = 1'b0;
      if (cmd) begin
         for (int b = 1; b < BL; b++) begin
            drive_wr(exp_own, base + 64'(b));
            #1;
            check({tag, " wr beat"}, m_if.wr_data, base + 64'(b));
            check({tag, " wr cmd_en"}, 64'(m_if.cmd_en), 64'd0);
            check({tag, " wr ready"}, 64'(s0_if.ready | s1_if.ready), 64'd0);
            tick();
         end
         drive_wr(exp_own, base + 64'(BL));
         #1;
         check({tag, " wr after"}, m_if.wr_data, 64'd0);
         check({tag, " wr end cmd_en"}, 64'(m_if.cmd_en), 64'd0);
      end else begin
         got = 0;
         timed_out = 1'b1;
         for (int k = 1; k <= TMO; k++) begin
            vld = (got < nvalid) && (!gaps || ((TMO - k) < (nvalid - got)) ||
                                     ($urandom_range(0, 2) != 0));
            m_if.rd_data_valid = vld;
            m_if.rd_data = base + 64'(got);
            #1;
            check({tag, " own rvalid"}, 64'(exp_own ? s1_if.rd_data_valid : s0_if.rd_data_valid), 64'(vld));
            check({tag, " other rvalid"}, 64'(exp_own ? s0_if.rd_data_valid : s1_if.rd_data_valid), 64'd0);
            if (vld) check({tag, " rdata"}, exp_own ? s1_if.rd_data : s0_if.rd_data, base + 64'(got));
            check({tag, " rd err"}, 64'(rd_timeout_err), 64'd0);
            if (vld) got++;
            tick();
            if (got == BL) begin
               timed_out = 1'b0;
               break;
            end
         end
         // back in idle: a stray beat must not reach the requester
         m_if.rd_data_valid = 1'b1;
         m_if.rd_data = 64'hDEAD_BEEF;
         #1;
         check({tag, " timeout err"}, 64'(rd_timeout_err), 64'(timed_out));
         check({tag, " stray rvalid"}, 64'(s0_if.rd_data_valid | s1_if.rd_data_valid), 64'd0);
         check({tag, " rd end cmd_en"}, 64'(m_if.cmd_en), 64'd0);
      end
      tick();
      m_if.rd_data_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [1:0] rq;
      logic       rc;
      logic       eo;
      vecs[0] = '{2'b11, 1'b1, 21'h00123, 21'h00456, 1, 4, 64'h0100, 1'b0};
      vecs[1] = '{2'b11, 1'b1, 21'h00124, 21'h00457, 0, 4, 64'h0200, 1'b1};
      vecs[2] = '{2'b11, 1'b0, 21'h00125, 21'h00458, 2, 4, 64'h0300, 1'b0};
      vecs[3] = '{2'b01, 1'b1, 21'h00500, 21'h00000, 2, 4, 64'h5500, 1'b0};
      vecs[4] = '{2'b10, 1'b0, 21'h00000, 21'h01000, 0, 4, 64'h000A, 1'b1};
      vecs[5] = '{2'b01, 1'b0, 21'h00200, 21'h00000, 0, 2, 64'h0700, 1'b0};
      vecs[6] = '{2'b01, 1'b1, 21'h00201, 21'h00000, 1, 4, 64'h0800, 1'b0};
      vecs[7] = '{2'b10, 1'b1, 21'h00000, 21'h00333, 3, 4, 64'h0900, 1'b1};
      vecs[8] = '{2'b11, 1'b1, 21'h00077, 21'h00088, 0, 4, 64'h0A00, 1'b0};

      s0_if.cmd_en = 1'b0;  s1_if.cmd_en = 1'b0;
      s0_if.cmd = 1'b0;     s1_if.cmd = 1'b0;
      s0_if.addr = 21'd0;   s1_if.addr = 21'd0;
      s0_if.wr_data = 64'd0; s1_if.wr_data = 64'd0;
      s0_if.data_mask = 8'h0F; s1_if.data_mask = 8'hF0;
      m_if.ready = 1'b1;
      m_if.rd_data_valid = 1'b1;
      m_if.rd_data = 64'h1234;
      reset = 1'b1;
      tick();
      tick();
      check("rst cmd_en", 64'(m_if.cmd_en), 64'd0);
      check("rst addr", 64'(m_if.addr), 64'd0);
      check("rst cmd", 64'(m_if.cmd), 64'd0);
      check("rst ready", 64'({s1_if.ready, s0_if.ready}), 64'd0);
      check("rst rvalid", 64'({s1_if.rd_data_valid, s0_if.rd_data_valid}), 64'd0);
      check("rst err", 64'(rd_timeout_err), 64'd0);
      reset = 1'b0;
      pri = 1'b0;
      m_if.ready = 1'b0;
      m_if.rd_data_valid = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].reqm, vecs[i].cmd, vecs[i].a0, vecs[i].a1, vecs[i].lat,
                 vecs[i].nvalid, vecs[i].base, vecs[i].exp_own, 1'b0, $sformatf("vec%0d", i));
      end

      // reset lands during write beat 2
      s0_if.cmd_en = 1'b1;
      s0_if.cmd = 1'b1;
      s0_if.addr = 21'h00ABC;
      drive_wr(1'b0, 64'h3000);
      tick();
      m_if.ready = 1'b1;
      #1;
      check("abort ready", 64'(s0_if.ready), 64'd1);
      tick();
      s0_if.cmd_en = 1'b0;
      m_if.ready = 1'b0;
      drive_wr(1'b0, 64'h3001);
      tick();
      drive_wr(1'b0, 64'h3002);
      reset = 1'b1;
      #1;
      check("abort beat2", m_if.wr_data, 64'h3002);
      tick();
      reset = 1'b0;
      pri = 1'b0;
      drive_wr(1'b0, 64'h3003);
      m_if.ready = 1'b1;
      #1;
      check("abort cmd_en", 64'(m_if.cmd_en), 64'd0);
      check("abort no beat", m_if.wr_data, 64'd0);
      check("abort ready0", 64'({s1_if.ready, s0_if.ready}), 64'd0);
      check("abort addr", 64'(m_if.addr), 64'd0);
      tick();
      m_if.ready = 1'b0;
      run_txn(2'b11, 1'b1, 21'h00011, 21'h00022, 0, 4, 64'h4000, 1'b0, 1'b0, "post_abort");

      for (int n = 0; n < 40; n++) begin
         rq = 2'($urandom_range(1, 3));
         rc = 1'($urandom_range(0, 1));
         eo = (rq == 2'b11) ? pri : rq[1];
         run_txn(rq, rc, 21'($urandom), 21'($urandom), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : BL,
                 {32'($urandom), 32'($urandom)}, eo, 1'b1, $sformatf("rnd%0d", n));
      end

`ifdef BURST_ARB_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pri = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_txn(2'b01, 1'b1, 21'h00010, 21'h00020, 0, 4, 64'h6000, 1'b0, 1'b0, "stat0");
      end
      run_txn(2'b10, 1'b1, 21'h00010, 21'h00020, 0, 4, 64'h7000, 1'b1, 1'b0, "stat1");
      check("grants0", 64'(grants0), 64'd3);
      check("grants1", 64'(grants1), 64'd1);
      check("busy_cycles", 64'(busy_cycles), 64'd16);
      force dut.grants0_q = 16'hFFFF;
      #1;
      release dut.grants0_q;
      run_txn(2'b01, 1'b1, 21'h00010, 21'h00020, 0, 4, 64'h8000, 1'b0, 1'b0, "stat_sat");
      check("grants0 sat", 64'(grants0), 64'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/burst_bus_arbiter.md
BURST_BUS_ARBITER -- requirements
Module: burst_bus_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning 64-bit beats per burst, read or write.
REQ-002 SHALL have parameter RD_TIMEOUT, default 64, meaning maximum cycles from read acceptance to the last rd_data_valid.
REQ-003 SHALL have port clk  input  1  memory clock shared by all three bus interfaces.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s0  burst_bus_if.slave  --  requester 0 (addr 21, cmd, cmd_en, ready, wr_data 64, data_mask 8, rd_data 64, rd_data_valid).
REQ-006 SHALL have port s1  burst_bus_if.slave  --  requester 1, same signal set as s0.
REQ-007 SHALL have port m  burst_bus_if.master  --  single memory controller port.
REQ-008 SHALL have port rd_timeout_err  output  1  one-cycle pulse when a read burst times out.

Function
REQ-009 SHALL implement the states IDLE, CMD, WR_DATA and RD_DATA.
REQ-010 IDLE: on any s*.cmd_en, SHALL latch the winner as owner and go to CMD the next cycle; m.cmd_en SHALL be registered, so it is high 1 cycle after the request.
REQ-011 Arbitration SHALL be round-robin: the port not served last wins a simultaneous request; after reset, s0 has priority.
REQ-012 CMD: m.addr, m.cmd, m.wr_data and m.data_mask SHALL come from the owner; m.cmd_en SHALL be held until m.ready.
REQ-013 s<owner>.ready SHALL equal m.ready combinationally; the non-owner's ready SHALL be 0.
REQ-014 On CMD with m.ready and cmd=1, beat 0 SHALL transfer that cycle and the block SHALL go to WR_DATA.
REQ-015 WR_DATA: the owner's wr_data SHALL be forwarded for exactly BURST_LEN-1 further consecutive cycles, then the block SHALL return to IDLE.
REQ-016 On CMD with m.ready and cmd=0, the block SHALL go to RD_DATA.
REQ-017 RD_DATA: m.rd_data/rd_data_valid SHALL be routed to the owner only; the non-owner's rd_data_valid SHALL be 0.
REQ-018 RD_DATA SHALL return to IDLE on the BURST_LEN-th valid beat.
REQ-019 Beat and timeout counters SHALL be sized $clog2(BURST_LEN+1) and $clog2(RD_TIMEOUT+1) bits.
REQ-020 If RD_TIMEOUT cycles elapse in RD_DATA, the block SHALL pulse rd_timeout_err, go to IDLE and discard late beats until the next grant.
REQ-021 A new grant SHALL occur only from IDLE; there is at least 1 idle cycle between bursts.
REQ-022 A requester dropping cmd_en in CMD before ready is a protocol violation; the block SHALL still hold m.cmd_en until ready.
REQ-023 Outside CMD, m.cmd_en SHALL be 0; m.data_mask SHALL pass through from the owner.

Reset
REQ-024 Reset SHALL force IDLE, m.cmd_en=0, m.addr=0, m.cmd=0, both s*.ready=0, both s*.rd_data_valid=0, rd_timeout_err=0 and round-robin pointer=s0.
REQ-025 Reset mid-burst SHALL abort the burst immediately with no further beats forwarded.

Configuration
REQ-026 Macro BURST_ARB_STATS_EN defined: the block SHALL add outputs grants0 and grants1 (16-bit saturating, +1 per grant) and busy_cycles (32-bit wrapping, +1 per non-IDLE cycle), all cleared by reset.
REQ-027 Macro BURST_ARB_STATS_EN undefined: those ports and counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-028 Package burst_arb_pkg SHALL hold the state enum, ADDR_W=21, DATA_W=64 and MASK_W=8.
REQ-029 Sub-module rr_arbiter2 SHALL contain the 2-way round-robin pointer and grant logic: inputs req[1:0] and advance; output grant index.

Verification
REQ-030 Bench SHALL cover: s0 write at addr 0x500, ready after 3 cycles -> m.cmd_en high 3 cycles, 4 beats forwarded on consecutive cycles starting the ready cycle, s1.ready=0 throughout.
REQ-031 Bench SHALL cover: s0 and s1 request in the same cycle after reset -> s0 granted first, s1 next; then both request again -> s0 granted first.
REQ-032 Bench SHALL cover: s1 read at 0x1000, data 0xA..0xD on 4 valid beats -> only s1.rd_data_valid pulses, 4 times, and the block returns to IDLE.
REQ-033 Bench SHALL cover: read with only 2 valid beats -> rd_timeout_err pulses after 64 cycles in RD_DATA and the next s0 request is granted.
REQ-034 Bench SHALL cover: reset asserted during WR_DATA beat 2 -> next cycle m.cmd_en=0, state IDLE, no further beats.
REQ-035 Bench SHALL cover, with BURST_ARB_STATS_EN: 3 s0 grants and 1 s1 grant -> grants0=3, grants1=1; grants0 at 0xFFFF stays saturated.
